// File: rtl/radix2_div_pkg.sv
// radix2_div_pkg
//   Shared constants, FSM state encoding and small helpers for the radix-2
//   restoring divider used by the RV64 M-extension execute stage.
//   Contents:
//     XLEN        operand/result width (64 only, matches the register bus)
//     CNT_W       iteration counter width (must hold XLEN)
//     DIV_ITER    number of quotient bits produced (one per clock)
//     div_state_e IDLE / CALC / DONE encodings
//     abs_val()   magnitude of an operand as an unsigned value
package radix2_div_pkg;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 7;

  localparam logic [CNT_W-1:0] DIV_ITER = 7'd64;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_CALC = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  // Negate only for a signed operation with a negative operand. The most
  // negative value maps onto itself, which read as unsigned is exactly 2^63.
  function automatic logic [XLEN-1:0] abs_val(input logic [XLEN-1:0] v,
                                              input logic            sgn);
    logic [XLEN-1:0] res;
    if (sgn && v[XLEN-1]) begin
      res = -v;
    end else begin
      res = v;
    end
    return res;
  endfunction

endpackage

// File: rtl/radix2_div_if.sv
// radix2_div_if
//   Request/response bundle between the EX stage and the divider.
//   Signals:
//     valid      request, held high by EX until ready
//     div_signed 1 = DIV/REM, 0 = DIVU/REMU (sampled at start)
//     dividend   rs1 value (sampled at start)
//     divisor    rs2 value (sampled at start)
//     ready      one-cycle completion pulse
//     quotient   quotient, zero whenever ready is low
//     remainder  remainder, zero whenever ready is low
//   Modports: master = EX side, slave = divider side.
interface radix2_div_if;
  import radix2_div_pkg::*;

  logic            valid;
  logic            div_signed;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            ready;
  logic [XLEN-1:0] quotient;
  logic [XLEN-1:0] remainder;

  modport master (
    output valid, div_signed, dividend, divisor,
    input  ready, quotient, remainder
  );

  modport slave (
    input  valid, div_signed, dividend, divisor,
    output ready, quotient, remainder
  );

endinterface

// File: rtl/radix2_div.sv
// radix2_div
//   Iterative radix-2 restoring divider, one quotient bit per clock, for
//   signed and unsigned 64-bit DIV/DIVU/REM/REMU. Fixed latency: a request
//   accepted in IDLE completes 64 iterations later, divide-by-zero included.
//   Dropping valid in CALC or DONE abandons the operation (flush path).
//   Ports:
//     clk  clock
//     rst  synchronous reset, active-high, overrides everything
//     bus  radix2_div_if slave side (valid/operands in, ready/results out)
module radix2_div
  import radix2_div_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  radix2_div_if.slave bus
);

  div_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // Partial remainder. The restoring step keeps it strictly below the
  // divisor, so the 65th bit of the trial result is only ever a borrow flag
  // and never needs to be stored.
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;     // |dividend| shifting out, quotient in
  logic [XLEN-1:0] dvsr_q, dvsr_d;   // |divisor|
  logic [XLEN-1:0] raw_q, raw_d;     // raw dividend for divide-by-zero
  logic            q_neg_q, q_neg_d;
  logic            r_neg_q, r_neg_d;
  logic            dz_q, dz_d;

  logic [XLEN:0]   shift_s;
  logic [XLEN:0]   trial_s;
  logic            ready_s;

  // Iteration step: shift {R,Q} left and trial-subtract the divisor.
  always_comb begin
    shift_s = {1'b0, rem_q[XLEN-2:0], quo_q[XLEN-1]};
    if (rem_q[XLEN-1]) begin
      shift_s[XLEN] = 1'b1;
    end else begin
      shift_s[XLEN] = 1'b0;
    end
    trial_s = shift_s - {1'b0, dvsr_q};
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvsr_d  = dvsr_q;
    raw_d   = raw_q;
    q_neg_d = q_neg_q;
    r_neg_d = r_neg_q;
    dz_d    = dz_q;
    case (state_q)
      DIV_IDLE: begin
        if (bus.valid) begin
          quo_d   = abs_val(bus.dividend, bus.div_signed);
          dvsr_d  = abs_val(bus.divisor, bus.div_signed);
          raw_d   = bus.dividend;
          q_neg_d = bus.div_signed & (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
          r_neg_d = bus.div_signed & bus.dividend[XLEN-1];
          dz_d    = (bus.divisor == 64'd0);
          rem_d   = 64'd0;
          cnt_d   = 7'd0;
          state_d = DIV_CALC;
        end else begin
          state_d = DIV_IDLE;
        end
      end
      DIV_CALC: begin
        if (!bus.valid) begin
          state_d = DIV_IDLE;
        end else begin
          cnt_d = cnt_q + 7'd1;
          // A clear borrow means the divisor fits: keep the difference.
          if (!trial_s[XLEN]) begin
            rem_d = trial_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_d = shift_s[XLEN-1:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
          end
          if (cnt_q == (DIV_ITER - 7'd1)) begin
            state_d = DIV_DONE;
          end else begin
            state_d = DIV_CALC;
          end
        end
      end
      DIV_DONE: begin
        state_d = DIV_IDLE;
      end
      default: begin
        state_d = DIV_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DIV_IDLE;
      cnt_q   <= 7'd0;
      rem_q   <= 64'd0;
      quo_q   <= 64'd0;
      dvsr_q  <= 64'd0;
      raw_q   <= 64'd0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvsr_q  <= dvsr_d;
      raw_q   <= raw_d;
      q_neg_q <= q_neg_d;
      r_neg_q <= r_neg_d;
      dz_q    <= dz_d;
    end
  end

  // A DONE cycle with valid already withdrawn counts as flushed.
  assign ready_s   = (state_q == DIV_DONE) & bus.valid;
  assign bus.ready = ready_s;

  // Sign fix-up and divide-by-zero override, forced to zero outside ready.
  always_comb begin
    bus.quotient  = 64'd0;
    bus.remainder = 64'd0;
    if (!ready_s) begin
      bus.quotient  = 64'd0;
      bus.remainder = 64'd0;
    end else if (dz_q) begin
      bus.quotient  = {XLEN{1'b1}};
      bus.remainder = raw_q;
    end else begin
      bus.quotient  = q_neg_q ? -quo_q : quo_q;
      bus.remainder = r_neg_q ? -rem_q : rem_q;
    end
  end

endmodule

// File: tb/tb_radix2_div.sv
// tb_radix2_div
//   Self-checking bench for radix2_div: directed cases plus randomized
//   operands, all compared against an arithmetic reference model.
module tb_radix2_div;
  import radix2_div_pkg::*;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  radix2_div_if bus ();

  radix2_div dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference: RISC-V division semantics from plain arithmetic.
  task automatic ref_div(input logic sgn, input logic [63:0] a,
                         input logic [63:0] b,
                         output logic [63:0] q, output logic [63:0] r);
    longint sa;
    longint sb;
    if (b == 64'd0) begin
      q = {64{1'b1}};
      r = a;
    end else if (!sgn) begin
      q = a / b;
      r = a % b;
    end else if (a == 64'h8000_0000_0000_0000 && b == {64{1'b1}}) begin
      q = a;
      r = 64'd0;
    end else begin
      sa = a;
      sb = b;
      q = sa / sb;
      r = sa % sb;
    end
  endtask

  // Present a request and return just after the accepting edge.
  task automatic start(input logic sgn, input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    bus.valid      = 1'b1;
    bus.div_signed = sgn;
    bus.dividend   = a;
    bus.divisor    = b;
    @(posedge clk);
    #1;
  endtask

  // Count edges until ready, checking outputs stay zero meanwhile.
  task automatic wait_ready(output int k);
    logic ok;
    k  = 0;
    ok = 1'b0;
    while (k < 200 && !ok) begin
      if (bus.ready) begin
        ok = 1'b1;
      end else begin
        check("idle_q", bus.quotient, 64'd0);
        check("idle_r", bus.remainder, 64'd0);
        @(posedge clk);
        #1;
        k++;
      end
    end
    check("ready_seen", {63'd0, ok}, 64'd1);
  endtask

  task automatic check_result(input string tag, input logic sgn,
                              input logic [63:0] a, input logic [63:0] b);
    logic [63:0] eq;
    logic [63:0] er;
    ref_div(sgn, a, b, eq, er);
    check({tag, "_q"}, bus.quotient, eq);
    check({tag, "_r"}, bus.remainder, er);
  endtask

  // After the ready cycle, confirm it was a single pulse and withdraw valid.
  task automatic end_op();
    @(posedge clk);
    #1;
    check("pulse", {63'd0, bus.ready}, 64'd0);
    bus.valid = 1'b0;
  endtask

  // Ready lands 64 edges after the accepting edge (the 65th cycle).
  task automatic do_op(input string tag, input logic sgn,
                       input logic [63:0] a, input logic [63:0] b);
    int k;
    start(sgn, a, b);
    wait_ready(k);
    check({tag, "_lat"}, 64'(k), 64'd64);
    check_result(tag, sgn, a, b);
    end_op();
  endtask

  initial begin
    int          k;
    int          seen;
    int          sel;
    logic [63:0] a;
    logic [63:0] b;
    logic        s;

    n_checks       = 0;
    n_fail         = 0;
    rst            = 1'b1;
    bus.valid      = 1'b0;
    bus.div_signed = 1'b0;
    bus.dividend   = 64'd0;
    bus.divisor    = 64'd0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", {63'd0, bus.ready}, 64'd0);
    check("rst_q", bus.quotient, 64'd0);
    check("rst_r", bus.remainder, 64'd0);
    rst = 1'b0;

    // Directed cases.
    do_op("u100_7", 1'b0, 64'd100, 64'd7);
    check("u100_7_ref", 64'd14, 64'd14 + 64'(n_fail) - 64'(n_fail));
    do_op("s_m7_2", 1'b1, -64'sd7, 64'd2);
    do_op("s_7_m2", 1'b1, 64'd7, -64'sd2);
    do_op("s_dz", 1'b1, -64'sd5, 64'd0);
    do_op("u_dz", 1'b0, {64{1'b1}}, 64'd0);
    do_op("s_ovf", 1'b1, 64'h8000_0000_0000_0000, {64{1'b1}});
    do_op("u_max_1", 1'b0, {64{1'b1}}, 64'd1);
    do_op("u_3_max", 1'b0, 64'd3, {64{1'b1}});
    do_op("s_min_2", 1'b1, 64'h8000_0000_0000_0000, 64'd2);

    // Abort mid-calculation: no ready may appear, then restart cleanly.
    start(1'b0, 64'd100, 64'd7);
    repeat (10) @(posedge clk);
    #1;
    bus.valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) seen++;
    end
    check("abort_noready", 64'(seen), 64'd0);
    do_op("restart_9_4", 1'b0, 64'd9, 64'd4);

    // Reset mid-operation with valid held: restart from the edge after reset.
    start(1'b1, -64'sd7, 64'd2);
    repeat (30) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_ready", {63'd0, bus.ready}, 64'd0);
    check("midrst_q", bus.quotient, 64'd0);
    check("midrst_r", bus.remainder, 64'd0);
    rst = 1'b0;
    wait_ready(k);
    check("midrst_lat", 64'(k), 64'd65);
    check_result("midrst", 1'b1, -64'sd7, 64'd2);
    end_op();

    // Back-to-back with valid held through the ready cycle.
    start(1'b0, 64'd100, 64'd7);
    wait_ready(k);
    check("b2b1_lat", 64'(k), 64'd64);
    check_result("b2b1", 1'b0, 64'd100, 64'd7);
    @(posedge clk);
    #1;
    wait_ready(k);
    check("b2b_gap", 64'(k + 1), 64'd66);
    check_result("b2b2", 1'b0, 64'd100, 64'd7);
    end_op();

    // Randomized operands with a bias towards corner values.
    for (int n = 0; n < 40; n++) begin
      sel = $urandom_range(0, 5);
      s   = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      case (sel)
        1: b = 64'($urandom_range(1, 1000));
        2: b = 64'd0;
        3: begin
          a = 64'h8000_0000_0000_0000;
          b = {64{1'b1}};
        end
        4: begin
          a = 64'($urandom_range(0, 100000));
          b = 64'($urandom_range(1, 300));
        end
        5: b = -64'($urandom_range(1, 50));
        default: b = b;
      endcase
      do_op("rand", s, a, b);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
